// File: rtl/tt_user_module_341520747710120530_if.sv
// Purpose : TinyTapeout user-slot pin bundle for the 7-segment counter.
// Signals : io_in[7:0]  - clk, reset, hold, dir, prescale select P[3:0]
//           io_out[7:0] - segments a-g (bits 6:0) and decimal point (bit 7)
// Modports: master drives io_in and observes io_out; slave is the counter.
interface tt_user_module_341520747710120530_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);
endinterface

// File: rtl/tt_user_module_341520747710120530.sv
// Purpose : single-digit 7-segment up/down counter with power-of-two prescaler.
//           The digit steps every 2^P clocks; the decimal point toggles on each wrap.
// Ports   : bus.io_in[0]    clk (rising edge)
//           bus.io_in[1]    reset, synchronous active-high
//           bus.io_in[2]    hold, freezes prescaler, digit and dp
//           bus.io_in[3]    dir, 0 = up, 1 = down
//           bus.io_in[7:4]  P, prescale select
//           bus.io_out[6:0] segments a-g, active-high
//           bus.io_out[7]   decimal point
// Config  : define SEVSEG_HEX_EN for a 0-F hex counter; default is decimal 0-9.
module tt_user_module_341520747710120530 #(
    parameter int unsigned PRE_W = 15
) (
    tt_user_module_341520747710120530_if.slave bus
);

`ifdef SEVSEG_HEX_EN
    localparam logic [3:0] DIGIT_MAX = 4'hF;
`else
    localparam logic [3:0] DIGIT_MAX = 4'd9;
`endif

    logic             clk;
    logic             reset;
    logic             hold;
    logic             dir;
    logic [3:0]       p;

    logic [PRE_W-1:0] pre;
    logic [3:0]       digit;
    logic             dp;

    logic [PRE_W-1:0] mask;
    logic             tick;
    logic [3:0]       digit_next;
    logic             wrap;
    logic [6:0]       seg;

    assign clk   = bus.io_in[0];
    assign reset = bus.io_in[1];
    assign hold  = bus.io_in[2];
    assign dir   = bus.io_in[3];
    assign p     = bus.io_in[7:4];

    // Tick when the low P prescaler bits are all ones (P=0 ticks every clock).
    always_comb begin
        mask = PRE_W'((32'(1) << p) - 32'(1));
        tick = (p == 4'd0) || ((pre & mask) == mask);
    end

    // Next digit value and wrap detection for the current direction.
    always_comb begin
        digit_next = digit;
        wrap       = 1'b0;
        if (!dir) begin
            if (digit == DIGIT_MAX) begin
                digit_next = 4'd0;
                wrap       = 1'b1;
            end else begin
                digit_next = digit + 4'd1;
            end
        end else begin
            if (digit == 4'd0) begin
                digit_next = DIGIT_MAX;
                wrap       = 1'b1;
            end else begin
                digit_next = digit - 4'd1;
            end
        end
    end

    // State update: reset wins over hold, hold freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre   <= '0;
            digit <= 4'd0;
            dp    <= 1'b0;
        end else if (!hold) begin
            pre <= pre + PRE_W'(1);
            if (tick) begin
                digit <= digit_next;
                if (wrap) begin
                    dp <= ~dp;
                end
            end
        end
    end

    // Segment decode of the registered digit; unused codes blank.
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
`ifdef SEVSEG_HEX_EN
            4'd10: seg = 7'h77;
            4'd11: seg = 7'h7C;
            4'd12: seg = 7'h39;
            4'd13: seg = 7'h5E;
            4'd14: seg = 7'h79;
            4'd15: seg = 7'h71;
`endif
            default: seg = 7'h00;
        endcase
    end

    assign bus.io_out = {dp, seg};

endmodule

// File: tb/tb_tt_user_module_341520747710120530.sv
// Testbench for the 7-segment counter: directed scenarios plus randomized
// hold/dir/P/reset traffic, checked against a behavioural counter model.
module tb_tt_user_module_341520747710120530;

    logic       clk;
    logic [6:0] ctrl;   // {P[3:0], dir, hold, reset}

    tt_user_module_341520747710120530_if bus_if ();

    assign bus_if.io_in = {ctrl, clk};

    tt_user_module_341520747710120530 dut (
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Behavioural model: integer counters, arithmetic tick rule, lookup table.
    int m_pre;
    int m_val;
    int m_dp;
    int m_max;
    logic [6:0] seg_tab [16];

    function automatic void model_edge(input logic r, input logic h,
                                       input logic d, input int p);
        int period;
        bit t;
        if (r) begin
            m_pre = 0;
            m_val = 0;
            m_dp  = 0;
        end else if (!h) begin
            period = 1 << p;
            t      = ((m_pre % period) == period - 1);
            m_pre  = (m_pre + 1) % 32768;
            if (t) begin
                if (!d) begin
                    if (m_val == m_max) begin
                        m_val = 0;
                        m_dp  = 1 - m_dp;
                    end else begin
                        m_val = m_val + 1;
                    end
                end else begin
                    if (m_val == 0) begin
                        m_val = m_max;
                        m_dp  = 1 - m_dp;
                    end else begin
                        m_val = m_val - 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [7:0] model_out();
        return {m_dp[0], seg_tab[m_val]};
    endfunction

    // One clock edge with the given controls, then compare against the model.
    task automatic step(input logic r, input logic h, input logic d,
                        input logic [3:0] p, input string tag);
        logic [7:0] exp;
        ctrl = {p, d, h, r};
        @(posedge clk);
        #1;
        model_edge(r, h, d, int'(p));
        exp = model_out();
        total++;
        assert (bus_if.io_out === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, bus_if.io_out, exp);
        end
    endtask

    // Fixed-value check taken from hand-worked expectations.
    task automatic check_const(input logic [7:0] exp, input string tag);
        total++;
        assert (bus_if.io_out === exp)
        else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, bus_if.io_out, exp);
        end
    endtask

    logic [7:0] up_seq [10];
    logic       rr, hh, dd;
    logic [3:0] pp;

    initial begin
        total = 0;
        bad   = 0;
        ctrl  = 7'd0;
        m_pre = 0;
        m_val = 0;
        m_dp  = 0;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`ifdef SEVSEG_HEX_EN
        m_max = 15;
        seg_tab[10] = 7'h77; seg_tab[11] = 7'h7C; seg_tab[12] = 7'h39;
        seg_tab[13] = 7'h5E; seg_tab[14] = 7'h79; seg_tab[15] = 7'h71;
        up_seq = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77};
`else
        m_max = 9;
        up_seq = '{8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'hBF};
`endif

        #2;
        // Reset state
        step(1'b1, 1'b0, 1'b0, 4'd0, "reset");
        check_const(8'h3F, "reset_const");

        // Free-run up at P=0
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd0, "up_p0");
            check_const(up_seq[i], "up_seq_const");
        end
        for (int i = 0; i < 190; i++) step(1'b0, 1'b0, 1'b0, 4'd0, "up_run");

        // Mid-count reset with hold asserted
        step(1'b1, 1'b1, 1'b0, 4'd0, "reset_hold");
        check_const(8'h3F, "reset_hold_const");

        // Count down from reset
        step(1'b0, 1'b0, 1'b1, 4'd0, "down_first");
`ifndef SEVSEG_HEX_EN
        check_const(8'hEF, "down_first_const");
`endif
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 4'd0, "down_run");

        // Hold at 5
        step(1'b1, 1'b0, 1'b0, 4'd0, "reset2");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4'd0, "to_five");
        check_const(8'h6D, "five_const");
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b0, 4'd0, "hold");
            check_const(8'h6D, "hold_const");
        end
        step(1'b0, 1'b0, 1'b0, 4'd0, "release");
        check_const(8'h7D, "release_const");

        // Prescale P=3
        step(1'b1, 1'b0, 1'b0, 4'd3, "reset3");
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 4'd3, "p3");
            if (i == 7)  check_const(8'h3F, "p3_e7");
            if (i == 8)  check_const(8'h06, "p3_e8");
            if (i == 15) check_const(8'h06, "p3_e15");
            if (i == 16) check_const(8'h5B, "p3_e16");
        end

        // Randomized controls, including mid-run P and dir changes
        rr = 1'b0; hh = 1'b0; dd = 1'b0; pp = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0)
                pp = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                                 : 4'($urandom_range(0, 3));
            if (i % 37 == 0) dd = 1'($urandom_range(0, 1));
            hh = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 199) == 0);
            step(rr, hh, dd, pp, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
